sipo_deserializer: RTL

- Serial-in/parallel-out deserializer that assembles a 1-bit serial stream into WIDTH-bit words.
- Sits directly upstream of the 4-bit parallel register stage and supplies its parallel input word.
- Uses valid/ready handshakes on both sides.
- An assembly shift register plus an output holding register let one complete word wait while the next word's bits are stalled.

---
 rtl/sipo_deserializer_pkg.sv | 15 +
 rtl/sipo_out_reg.sv | 27 ++
 rtl/sipo_deserializer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Holds the FSM state encoding and the bit-counter width calculation.
package sipo_deserializer_pkg;

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Wide enough to hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register with a valid/ready handshake.
// A load always wins; otherwise a consumed word drops p_valid while p_data holds its value.
module sipo_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             p_ready,
    output logic             p_valid,
    output logic [WIDTH-1:0] p_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_data  <= '0;
        end else if (load) begin
            p_valid <= 1'b1;
            p_data  <= load_data;
        end else if (p_valid && p_ready) begin
            p_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Assembles a 1-bit serial stream into WIDTH-bit words with valid/ready on both sides.
// state    | meaning
// ST_SHIFT | accepting serial bits into the assembly register
// ST_STALL | assembly register holds a complete word, output register still occupied
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_sof,
    output logic             s_ready,
    output logic             p_valid,
    output logic [WIDTH-1:0] p_data,
    input  logic             p_ready,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] asm_reg, asm_nxt;
    logic [WIDTH-1:0] shifted, fresh;
    logic [WIDTH-1:0] load_data;
    logic             load;
    logic             accept;
    logic             out_free;
    logic             err_set;

    assign s_ready  = (state == ST_SHIFT);
    assign accept   = s_valid && s_ready;
    assign out_free = !p_valid || p_ready;

    // A start-of-word bit restarts assembly from that bit alone.
    always_comb begin
        shifted = '0;
        fresh   = '0;
        if (MSB_FIRST) begin
            shifted = {asm_reg[WIDTH-2:0], s_data};
            fresh   = {{(WIDTH-1){1'b0}}, s_data};
        end else begin
            shifted = {s_data, asm_reg[WIDTH-1:1]};
            fresh   = {s_data, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SHIFT;
            cnt       <= '0;
            asm_reg   <= '0;
            frame_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            asm_reg <= asm_nxt;
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        asm_nxt   = asm_reg;
        load      = 1'b0;
        load_data = shifted;
        err_set   = 1'b0;
        case (state)
            ST_SHIFT: begin
                if (accept) begin
                    if (s_sof) begin
                        asm_nxt = fresh;
                        cnt_nxt = CW'(1);
                        err_set = (cnt != '0);
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        asm_nxt = shifted;
                        if (out_free) begin
                            load    = 1'b1;
                            cnt_nxt = '0;
                        end else begin
                            state_nxt = ST_STALL;
                        end
                    end else begin
                        asm_nxt = shifted;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            ST_STALL: begin
                load_data = asm_reg;
                if (p_valid && p_ready) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            default: state_nxt = ST_SHIFT;
        endcase
    end

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .p_ready  (p_ready),
        .p_valid  (p_valid),
        .p_data   (p_data)
    );

endmodule
